// File: rtl/addsub_pipe.sv
// Pipelined two's-complement add/subtract with carry split into STAGES registered slices.
// Optional macro ADDSUB_SAT_EN clamps signed overflow to saturation in the final stage.
module addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z,
  output logic             out_n,
  output logic             out_sat,
  output logic [TAG_W-1:0] out_tag
);

  localparam int S = WIDTH / STAGES;
  localparam int L = STAGES - 1;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_err
    $error("addsub_pipe: WIDTH must be a multiple of STAGES, STAGES in 1..WIDTH");
  end

  // Stage k holds an operation waiting to compute slice k; r_sum has slices below k filled.
  logic             r_vld [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_sum [STAGES];
  logic             r_cy  [STAGES];
  logic [TAG_W-1:0] r_tag [STAGES];

  logic [S:0]       w_add [STAGES];
  logic [WIDTH-1:0] w_sum [STAGES];

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_result;
  logic             r_out_c, r_out_v, r_out_z, r_out_n, r_out_sat;
  logic [TAG_W-1:0] r_out_tag;

  logic             w_adv;
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_final;
  logic             w_cout, w_cmsb, w_ovf, w_sat;

  assign w_adv    = out_ready | ~r_out_valid;
  assign in_ready = w_adv;

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_slice
    localparam logic [WIDTH-1:0] MASK = WIDTH'({S{1'b1}}) << (gi * S);
    assign w_add[gi] = {1'b0, r_a[gi][gi*S +: S]} + {1'b0, r_b[gi][gi*S +: S]}
                     + (S+1)'(r_cy[gi]);
    assign w_sum[gi] = (r_sum[gi] & ~MASK) | (WIDTH'(w_add[gi][S-1:0]) << (gi * S));
  end

  assign w_raw  = w_sum[L];
  assign w_cout = w_add[L][S];
  // Carry into the MSB recovered from the MSB sum bit and its operand bits.
  assign w_cmsb = w_raw[WIDTH-1] ^ r_a[L][WIDTH-1] ^ r_b[L][WIDTH-1];
  assign w_ovf  = w_cmsb ^ w_cout;

`ifdef ADDSUB_SAT_EN
  // Wrapped sign is opposite to the true sign, so it selects the clamp direction.
  assign w_final = w_ovf ? {~w_raw[WIDTH-1], {(WIDTH-1){w_raw[WIDTH-1]}}} : w_raw;
  assign w_sat   = w_ovf;
`else
  assign w_final = w_raw;
  assign w_sat   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) r_vld[k] <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_c      <= 1'b0;
      r_out_v      <= 1'b0;
      r_out_z      <= 1'b0;
      r_out_n      <= 1'b0;
      r_out_sat    <= 1'b0;
      r_out_tag    <= '0;
    end else if (w_adv) begin
      // SUB folds into ADD: invert B and the borrow.
      r_vld[0] <= in_valid;
      r_a[0]   <= in_a;
      r_b[0]   <= in_op ? ~in_b : in_b;
      r_cy[0]  <= in_op ? ~in_cin : in_cin;
      r_sum[0] <= '0;
      r_tag[0] <= in_tag;
      for (int k = 1; k < STAGES; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_a[k]   <= r_a[k-1];
        r_b[k]   <= r_b[k-1];
        r_sum[k] <= w_sum[k-1];
        r_cy[k]  <= w_add[k-1][S];
        r_tag[k] <= r_tag[k-1];
      end
      r_out_valid  <= r_vld[L];
      r_out_result <= w_final;
      r_out_c      <= w_cout;
      r_out_v      <= w_ovf;
      r_out_z      <= (w_final == '0);
      r_out_n      <= w_final[WIDTH-1];
      r_out_sat    <= w_sat;
      r_out_tag    <= r_tag[L];
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_c      = r_out_c;
  assign out_v      = r_out_v;
  assign out_z      = r_out_z;
  assign out_n      = r_out_n;
  assign out_sat    = r_out_sat;
  assign out_tag    = r_out_tag;

endmodule
